// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state encoding
// and the bundle of per-stage register controls.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '0;
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard indications into the controller and register controls back out to
// the pipeline; master is the pipeline side, slave is the controller.
interface pipeline_stall_ctrl_if;
  logic hazard;
  logic mispredict;
  logic ex_halt;
  logic mem_stall;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic ex_mem_write;
  logic mem_wb_write;
  logic is_halted;

  modport master (
    output hazard, mispredict, ex_halt, mem_stall,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  ex_mem_write, mem_wb_write, is_halted
  );

  modport slave (
    input  hazard, mispredict, ex_halt, mem_stall,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output ex_mem_write, mem_wb_write, is_halted
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] cur);
    if (&cur) return cur;
    return cur + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (inc)
      value <= sat_inc(value);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Converts raw hazard, mispredict, halt and memory-wait indications into
// per-stage register controls for the 5-stage core, with stall/flush counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state, state_next;
  logic          pending_flush, pending_next;
  logic [DW-1:0] drain_cnt, drain_next;
  logic          halted, halted_next;
  logic          stall_inc, flush_inc;
  logic          eff_mispredict;
  ctrl_t         ctrl;

  // pending_flush is only ever set while in MEM_WAIT, so OR-ing it in here
  // replays a mispredict that arrived during the memory wait on release.
  assign eff_mispredict = bus.mispredict | pending_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RUN;
      pending_flush <= 1'b0;
      drain_cnt     <= '0;
      halted        <= 1'b0;
    end else begin
      state         <= state_next;
      pending_flush <= pending_next;
      drain_cnt     <= drain_next;
      halted        <= halted_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending_flush;
    drain_next   = drain_cnt;
    halted_next  = halted;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    ctrl         = CTRL_FREEZE;

    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (bus.mem_stall) begin
          pending_next = pending_flush | bus.mispredict;
          state_next   = ST_MEM_WAIT;
        end else begin
          pending_next = 1'b0;
          state_next   = ST_RUN;
          ctrl         = CTRL_RUN;
          if (bus.ex_halt) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            drain_next        = DW'(DRAIN_CYCLES - 1);
            state_next        = ST_DRAIN;
          end else if (eff_mispredict) begin
            // A concurrent hazard is on a wrong-path instruction: no stall.
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            flush_inc         = 1'b1;
          end else if (bus.hazard) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            stall_inc         = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
        ctrl.ex_mem_write = !bus.mem_stall;
        ctrl.mem_wb_write = !bus.mem_stall;
        if (!bus.mem_stall) begin
          if (drain_cnt == '0) begin
            halted_next = 1'b1;
            state_next  = ST_HALTED;
          end else begin
            drain_next = drain_cnt - DW'(1);
          end
        end
      end

      ST_HALTED: ctrl = CTRL_FREEZE;

      default: state_next = ST_RUN;
    endcase
  end

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.if_id_write  = ctrl.if_id_write;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_bubble = ctrl.id_ex_bubble;
  assign bus.ex_mem_write = ctrl.ex_mem_write;
  assign bus.mem_wb_write = ctrl.mem_wb_write;
  assign bus.is_halted    = halted;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .value (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .value (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Vector-table bench for pipeline_stall_ctrl with a small counter width so
// saturation is reachable.
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  localparam int CNT_W        = 4;
  localparam int DRAIN_CYCLES = 2;
  localparam int SAT          = (1 << CNT_W) - 1;

  // input encoding {reset, hazard, mispredict, ex_halt, mem_stall}
  localparam logic [4:0] I_RST = 5'b10000;
  localparam logic [4:0] I_HZ  = 5'b01000;
  localparam logic [4:0] I_MP  = 5'b00100;
  localparam logic [4:0] I_EH  = 5'b00010;
  localparam logic [4:0] I_MS  = 5'b00001;

  // control encoding {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write}
  localparam logic [5:0] C_RUN = 6'b110011;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_EH  = 6'b011111;
  localparam logic [5:0] C_MP  = 6'b111111;
  localparam logic [5:0] C_HZ  = 6'b000111;
  localparam logic [5:0] C_DR  = 6'b001111;
  localparam logic [5:0] C_DRS = 6'b001100;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] in;
    logic [5:0] ctrl;
    logic       halted;
    int         stall;
    int         flush;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic v(input logic [4:0] in, input logic [5:0] c, input logic hl,
                   input int st, input int fl);
    vec_t t;
    t.in = in; t.ctrl = c; t.halted = hl; t.stall = st; t.flush = fl;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    vec_t       e;
    logic [5:0] got;
    logic       bad;
    @(posedge clk); #1;
    {reset, bus.hazard, bus.mispredict, bus.ex_halt, bus.mem_stall} = t.in;
    sb.push_back(t);
    @(negedge clk);
    e   = sb.pop_front();
    got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
           bus.ex_mem_write, bus.mem_wb_write};
    applied++;
    bad = 1'b0;
    if (got !== e.ctrl) begin
      $display("FAIL vec%0d ctrl: got %b want %b", applied, got, e.ctrl);
      bad = 1'b1;
    end
    if (bus.is_halted !== e.halted) begin
      $display("FAIL vec%0d is_halted: got %b want %b", applied, bus.is_halted, e.halted);
      bad = 1'b1;
    end
    if ($isunknown(stall_cycles) || int'(stall_cycles) != e.stall) begin
      $display("FAIL vec%0d stall_cycles: got %0d want %0d", applied, stall_cycles, e.stall);
      bad = 1'b1;
    end
    if ($isunknown(flush_count) || int'(flush_count) != e.flush) begin
      $display("FAIL vec%0d flush_count: got %0d want %0d", applied, flush_count, e.flush);
      bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.hazard     = 1'b0;
    bus.mispredict = 1'b0;
    bus.ex_halt    = 1'b0;
    bus.mem_stall  = 1'b0;
    repeat (2) @(posedge clk);

    // basic RUN behaviour and priority
    v(0,           C_RUN, 0, 0, 0);
    v(I_HZ,        C_HZ,  0, 0, 0);
    v(0,           C_RUN, 0, 1, 0);
    v(I_MP | I_HZ, C_MP,  0, 1, 0);
    v(0,           C_RUN, 0, 1, 1);
    v(I_MP,        C_MP,  0, 1, 1);
    // memory wait with a mispredict deferred to the release cycle
    v(I_MS,        C_FRZ, 0, 1, 2);
    v(I_MS | I_MP, C_FRZ, 0, 1, 2);
    v(I_MS,        C_FRZ, 0, 1, 2);
    v(0,           C_MP,  0, 1, 2);
    v(0,           C_RUN, 0, 1, 3);
    // hazard counted only on the release cycle
    v(I_MS | I_HZ, C_FRZ, 0, 1, 3);
    v(I_HZ,        C_HZ,  0, 1, 3);
    v(0,           C_RUN, 0, 2, 3);
    // release into a halt beats the pending flush; drain stretched by mem_stall
    v(I_MS | I_MP, C_FRZ, 0, 2, 3);
    v(I_EH,        C_EH,  0, 2, 3);
    v(I_HZ | I_MP, C_DR,  0, 2, 3);
    v(I_MS,        C_DRS, 0, 2, 3);
    v(I_MS,        C_DRS, 0, 2, 3);
    v(0,           C_DR,  0, 2, 3);
    v(I_HZ | I_MP | I_EH | I_MS, C_FRZ, 1, 2, 3);
    v(I_HZ,        C_FRZ, 1, 2, 3);
    v(I_RST,       C_FRZ, 1, 2, 3);
    v(0,           C_RUN, 0, 0, 0);
    // undisturbed drain: halted after the third edge
    v(I_EH,        C_EH,  0, 0, 0);
    v(0,           C_DR,  0, 0, 0);
    v(0,           C_DR,  0, 0, 0);
    v(I_MP,        C_FRZ, 1, 0, 0);
    v(I_RST,       C_FRZ, 1, 0, 0);
    v(0,           C_RUN, 0, 0, 0);
    // reset mid-DRAIN and mid-MEM_WAIT (pending flush must be dropped)
    v(I_EH,        C_EH,  0, 0, 0);
    v(I_RST,       C_DR,  0, 0, 0);
    v(0,           C_RUN, 0, 0, 0);
    v(I_MS | I_MP, C_FRZ, 0, 0, 0);
    v(I_RST | I_MS, C_FRZ, 0, 0, 0);
    v(0,           C_RUN, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // counter saturation: stall_cycles then flush_count driven past all-ones
    vecs.delete();
    for (int i = 0; i <= SAT + 1; i++)
      v(I_HZ, C_HZ, 0, (i > SAT) ? SAT : i, 0);
    for (int i = 0; i <= SAT + 1; i++)
      v(I_MP, C_MP, 0, SAT, (i > SAT) ? SAT : i);
    v(0,     C_RUN, 0, SAT, SAT);
    v(I_RST, C_RUN, 0, SAT, SAT);
    v(0,     C_RUN, 0, 0,   0);
    foreach (vecs[i]) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Turns the pipeline's raw hazard indications into per-stage register controls for the 5-stage RISC-V core.
- Inputs: hazard detection (load-use / ecall stall), EX-stage branch mispredict, EX-stage halting ecall, memory-not-ready.
- Outputs: PC and pipeline-register write enables, flush/bubble controls and the halt flag.
- Sequences multi-cycle events: memory waits with a deferred flush, halt drain. Keeps stall and flush performance counters.

Parameters:
- DRAIN_CYCLES, 2, cycles after a halting ecall leaves EX before is_halted asserts (lets EX/MEM and MEM/WB retire).
- CNT_W, 32, width of stall_cycles and flush_count.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- hazard  input  1  stall request from hazard detection; ID instruction must be held.
- mispredict  input  1  EX branch/jump resolved against prediction; corrected PC is presented to the PC mux this cycle.
- ex_halt  input  1  EX holds ecall with x17==10.
- mem_stall  input  1  instruction or data memory not ready; entire pipeline must freeze.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID enable.
- if_id_flush  output  1  IF/ID loads NOP.
- id_ex_bubble  output  1  ID/EX loads NOP (control bits zeroed).
- ex_mem_write  output  1  EX/MEM enable.
- mem_wb_write  output  1  MEM/WB enable.
- is_halted  output  1  registered; core stopped.
- stall_cycles  output  CNT_W  count of hazard-stall cycles.
- flush_count  output  CNT_W  count of applied mispredict flushes.

Behaviour:
- State register: RUN, MEM_WAIT, DRAIN, HALTED. Reset (synchronous) -> RUN.
- Reset also clears pending_flush, drain_cnt, is_halted, stall_cycles and flush_count to 0.
- Control outputs are combinational from state and inputs, evaluated in the same cycle, zero latency.
- RUN defaults: pc_write=1, if_id_write=1, ex_mem_write=1, mem_wb_write=1; if_id_flush=0, id_ex_bubble=0.
- RUN priority is mem_stall > ex_halt > mispredict > hazard:
  - mem_stall: all four write enables 0, no flush or bubble. pending_flush <= mispredict. Next state MEM_WAIT.
  - ex_halt: pc_write=0, if_id_flush=1, id_ex_bubble=1. drain_cnt <= DRAIN_CYCLES-1. Next state DRAIN.
  - mispredict: pc_write=1, if_id_flush=1, id_ex_bubble=1. flush_count++. The simultaneous hazard is ignored because the ID instruction is wrong-path, so stall_cycles is not incremented.
  - hazard: pc_write=0, if_id_write=0, id_ex_bubble=1. stall_cycles++.
- MEM_WAIT:
  - While mem_stall=1: all write enables 0. pending_flush |= mispredict.
  - On the first cycle mem_stall=0, apply the RUN rules, with mispredict treated as (mispredict | pending_flush). Clear pending_flush. Return to RUN, or go to DRAIN if ex_halt.
  - flush_count increments once per flush actually applied.
- DRAIN:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1. hazard and mispredict are ignored.
  - ex_mem_write and mem_wb_write follow !mem_stall. drain_cnt decrements only when mem_stall=0.
  - When drain_cnt==0 and mem_stall=0: is_halted <= 1 and next state HALTED.
- HALTED: all write enables 0, no flush or bubble, is_halted=1. Leaves only on reset.
- Counters saturate at all-ones; no wrap.
- stall_cycles counts only hazard-stall cycles in RUN, or in MEM_WAIT on the release cycle.
- Reset asserted in any state (including mid-DRAIN or mid-MEM_WAIT) takes effect at that edge. Outputs follow RUN rules in the next cycle.

Decomposition:
- Shared package/header (alongside the opcode definitions): state encoding constants ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_DRAIN=2'd2, ST_HALTED=2'd3.
- One sub-module, sat_counter (width param, inc, reset, value). Instantiated twice, for stall_cycles and flush_count.

Test Plan:
- hazard=1 for 1 cycle in RUN -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles 0->1; next cycle all defaults.
- mispredict=1 and hazard=1 together -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1, stall_cycles=0.
- mem_stall=1 for 3 cycles, mispredict pulsed in cycle 2 -> all enables 0 for 3 cycles; release cycle shows if_id_flush=1 and flush_count=1.
- ex_halt=1 with DRAIN_CYCLES=2 -> DRAIN for 2 cycles with flush/bubble and ex_mem_write=1; is_halted=1 on the 3rd edge; all enables 0 thereafter regardless of inputs.
- mem_stall=1 during DRAIN for 2 cycles -> drain_cnt holds and is_halted is delayed by exactly 2 cycles.
- Reset asserted mid-DRAIN; separately, counter preloaded to 2^CNT_W-1 then hazard -> next cycle state RUN, is_halted=0, counters 0; saturated counter stays at all-ones.
